mem_ctrl: RTL and testbench

- Responder side of the byte-wide memory request interface driven by the MEM stage.
- Also serves word-wide instruction fetches from the IF stage.
- Arbitrates one single-port, byte-wide RAM with registered read output (1-cycle read latency); MEM has strict priority.
- MEM requests pass straight through to RAM. IF fetches are assembled by a small FSM into 32-bit words; they can be preempted by MEM and flushed by IF.

---
 rtl/mem_ctrl_pkg.sv | 13 +
 rtl/mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: fetch FSM states and RAM defaults.
package mem_ctrl_pkg;

    localparam int         RAM_ADDR_W_DEF = 17;
    localparam int         FETCH_BYTES    = 4;
    localparam logic [7:0] ZERO_BYTE      = 8'h00;

    typedef enum logic {
        IF_IDLE  = 1'b0,
        IF_FETCH = 1'b1
    } if_state_e;

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: the MEM stage gets priority pass-through access to a single-port
// byte RAM, and the IF stage gets 32-bit little-endian fetches assembled one byte per cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IF_IDLE  | no fetch in progress; accepts if_req when if_clear is low
// IF_FETCH | issuing byte reads (when MEM is quiet) and capturing bytes
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_r_w,
    input  logic [31:0]       mem_req_addr,
    input  logic [7:0]        mem_req_data,
    output logic [7:0]        mem_data_o,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_clear,
    output logic [31:0]       if_inst_o,
    output logic              if_done,
    output logic              if_busy,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] fetch_base_q, fetch_base_d;
    logic [2:0]        issue_cnt_q, issue_cnt_d;
    logic              pend_q, pend_d;
    logic [1:0]        pend_idx_q, pend_idx_d;
    logic [7:0]        byte0_q, byte0_d;
    logic [7:0]        byte1_q, byte1_d;
    logic [7:0]        byte2_q, byte2_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic              if_done_q, if_done_d;
    logic              if_issue;

    // Address bits above the RAM width are intentionally ignored (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], mem_req_addr[31:ADDR_W]};

    // State register: all fetch-side flops, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IF_IDLE;
            fetch_base_q <= '0;
            issue_cnt_q  <= '0;
            pend_q       <= 1'b0;
            pend_idx_q   <= '0;
            byte0_q      <= ZERO_BYTE;
            byte1_q      <= ZERO_BYTE;
            byte2_q      <= ZERO_BYTE;
            if_inst_q    <= '0;
            if_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_base_q <= fetch_base_d;
            issue_cnt_q  <= issue_cnt_d;
            pend_q       <= pend_d;
            pend_idx_q   <= pend_idx_d;
            byte0_q      <= byte0_d;
            byte1_q      <= byte1_d;
            byte2_q      <= byte2_d;
            if_inst_q    <= if_inst_d;
            if_done_q    <= if_done_d;
        end
    end

    // Next-state: accept, issue-count, byte capture, completion and flush.
    always_comb begin
        state_d      = state_q;
        fetch_base_d = fetch_base_q;
        issue_cnt_d  = issue_cnt_q;
        pend_d       = pend_q;
        pend_idx_d   = pend_idx_q;
        byte0_d      = byte0_q;
        byte1_d      = byte1_q;
        byte2_d      = byte2_q;
        if_inst_d    = if_inst_q;
        if_done_d    = 1'b0;
        case (state_q)
            IF_IDLE: begin
                if (if_req && !if_clear) begin
                    state_d      = IF_FETCH;
                    fetch_base_d = if_addr[ADDR_W-1:0];
                    issue_cnt_d  = '0;
                    pend_d       = 1'b0;
                end
            end
            IF_FETCH: begin
                if (if_clear) begin
                    // Flush wins over a same-edge completion; the in-flight byte is dropped.
                    state_d = IF_IDLE;
                    pend_d  = 1'b0;
                end else begin
                    pend_d     = if_issue;
                    pend_idx_d = issue_cnt_q[1:0];
                    if (if_issue) begin
                        issue_cnt_d = issue_cnt_q + 3'd1;
                    end
                    if (pend_q) begin
                        case (pend_idx_q)
                            2'd0: byte0_d = ram_din;
                            2'd1: byte1_d = ram_din;
                            2'd2: byte2_d = ram_din;
                            default: begin
                                if_inst_d = {ram_din, byte2_q, byte1_q, byte0_q};
                                if_done_d = 1'b1;
                                state_d   = IF_IDLE;
                            end
                        endcase
                    end
                end
            end
            default: state_d = IF_IDLE;
        endcase
    end

    // Outputs: RAM port mux (MEM first, then IF issue) and registered status.
    always_comb begin
        if_issue = !rst && (state_q == IF_FETCH) && !mem_req
                   && (issue_cnt_q < 3'(FETCH_BYTES));
        ram_a    = '0;
        ram_wr   = 1'b0;
        ram_dout = ZERO_BYTE;
        if (!rst) begin
            if (mem_req) begin
                ram_a    = mem_req_addr[ADDR_W-1:0];
                ram_wr   = mem_r_w;
                ram_dout = mem_req_data;
            end else if (if_issue) begin
                ram_a = fetch_base_q + ADDR_W'(issue_cnt_q);
            end
        end
        mem_data_o = ram_din;
        if_inst_o  = if_inst_q;
        if_done    = if_done_q;
        if_busy    = (state_q == IF_FETCH);
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: RAM model, table-driven MEM vectors, hand-written fetch corner
// cases and randomized fetches with MEM preemption against a reference memory.
module tb_mem_ctrl;

    localparam int AW     = 17;
    localparam int RAM_SZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_req = 1'b0, mem_r_w = 1'b0;
    logic [31:0]   mem_req_addr = '0;
    logic [7:0]    mem_req_data = '0;
    logic [7:0]    mem_data_o;
    logic          if_req = 1'b0, if_clear = 1'b0;
    logic [31:0]   if_addr = '0;
    logic [31:0]   if_inst_o;
    logic          if_done, if_busy;
    logic [7:0]    ram_din, ram_dout;
    logic [AW-1:0] ram_a;
    logic          ram_wr;

    int n_cmp = 0;
    int n_err = 0;

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_r_w(mem_r_w), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_data_o(mem_data_o),
        .if_req(if_req), .if_addr(if_addr), .if_clear(if_clear),
        .if_inst_o(if_inst_o), .if_done(if_done), .if_busy(if_busy),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    // RAM with registered read and a backdoor write port for preloading.
    logic [7:0]    ram [RAM_SZ];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_a = '0;
    logic [7:0]    bd_d = '0;
    always @(posedge clk) begin
        if (bd_we) ram[bd_a] <= bd_d;
        else if (ram_wr) ram[ram_a] <= ram_dout;
        ram_din <= ram[ram_a];
    end

    // Reference memory contents as the bench believes them to be.
    logic [7:0] shadow [RAM_SZ];

    function automatic logic [7:0] sh(input logic [31:0] a);
        return shadow[a[AW-1:0]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_a = a[AW-1:0]; bd_d = d;
        tick();
        bd_we = 1'b0;
        shadow[a[AW-1:0]] = d;
    endtask

    // One fetch; preempt bit k puts a MEM access in cycle k after acceptance.
    // Expected completion: 5 edges plus one per MEM cycle before the 4th byte issues.
    task automatic run_fetch(input logic [31:0] base, input logic [31:0] preempt,
                             input bit rnd, input string tag);
        int edges, pre, issued;
        bit done_seen, busy_ok;
        logic [31:0] a;
        logic [7:0] d;
        logic w;
        if_req = 1'b1; if_addr = base;
        tick();
        if_req = 1'b0; if_addr = $urandom;
        edges = 0; pre = 0; issued = 0; done_seen = 0; busy_ok = 1;
        for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
            mem_req = (cyc < 32) ? preempt[cyc] : 1'b0;
            w = 1'b0; a = 32'h100 + 32'(cyc & 3); d = 8'h00;
            if (rnd) begin
                w = ($urandom_range(0, 3) == 0);
                a = w ? 32'h800 + 32'($urandom_range(0, 15))
                      : (($urandom_range(0, 1) == 0) ? 32'h400 + 32'($urandom_range(0, 63))
                                                     : 32'h800 + 32'($urandom_range(0, 15)));
                d = 8'($urandom);
            end
            mem_r_w = w; mem_req_addr = a; mem_req_data = d;
            if (issued < 4) begin
                if (mem_req) pre++;
                else issued++;
            end
            tick();
            edges++;
            if (mem_req && w) shadow[a[AW-1:0]] = d;
            if (mem_req && !w) chk({tag, " mem_rd"}, 32'(mem_data_o), 32'(sh(a)));
            mem_req = 1'b0; mem_r_w = 1'b0;
            if (if_done) begin
                done_seen = 1;
                chk({tag, " busy_at_done"}, 32'(if_busy), 32'd0);
            end else if (!if_busy) begin
                busy_ok = 0;
            end
        end
        chk({tag, " done"}, 32'(done_seen), 32'd1);
        chk({tag, " busy_during"}, 32'(busy_ok), 32'd1);
        chk({tag, " latency"}, 32'(edges), 32'(5 + pre));
        chk({tag, " inst"}, if_inst_o, {sh(base + 3), sh(base + 2), sh(base + 1), sh(base)});
        tick();
        chk({tag, " done_drop"}, 32'(if_done), 32'd0);
    endtask

    typedef struct {
        logic        r_w;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
    } mem_vec_t;

    mem_vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: registered outputs zero, RAM outputs forced to zero even with mem_req.
        mem_req = 1'b1; mem_r_w = 1'b1; mem_req_addr = 32'h123; mem_req_data = 8'h77;
        tick();
        tick();
        chk("rst ram_a", 32'(ram_a), 32'd0);
        chk("rst ram_wr", 32'(ram_wr), 32'd0);
        chk("rst ram_dout", 32'(ram_dout), 32'd0);
        chk("rst inst", if_inst_o, 32'd0);
        chk("rst done", 32'(if_done), 32'd0);
        chk("rst busy", 32'(if_busy), 32'd0);
        mem_req = 1'b0; mem_r_w = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle ram_a", 32'(ram_a), 32'd0);

        // Preload.
        load(32'h100, 8'h11); load(32'h101, 8'h22); load(32'h102, 8'h33); load(32'h103, 8'h44);
        load(32'h0, 8'h13); load(32'h1, 8'h05); load(32'h2, 8'h10); load(32'h3, 8'h00);
        load(32'h4, 8'hB7); load(32'h5, 8'h12); load(32'h6, 8'h34); load(32'h7, 8'h00);
        load(32'h1FFFE, 8'hEF); load(32'h1FFFF, 8'hBE);

        // Table: back-to-back MEM accesses.
        vecs[0] = '{1'b0, 32'h100, 8'h00, 8'h11};
        vecs[1] = '{1'b0, 32'h101, 8'h00, 8'h22};
        vecs[2] = '{1'b0, 32'h102, 8'h00, 8'h33};
        vecs[3] = '{1'b0, 32'h103, 8'h00, 8'h44};
        vecs[4] = '{1'b1, 32'h200, 8'hAB, 8'h00};
        vecs[5] = '{1'b0, 32'h200, 8'h00, 8'hAB};
        vecs[6] = '{1'b1, 32'h201, 8'h5A, 8'h00};
        vecs[7] = '{1'b0, 32'h201, 8'h00, 8'h5A};
        vecs[8] = '{1'b0, 32'hFFFE0100, 8'h00, 8'h11};
        vecs[9] = '{1'b0, 32'h103, 8'h00, 8'h44};
        for (int i = 0; i < 10; i++) begin
            mem_req = 1'b1; mem_r_w = vecs[i].r_w;
            mem_req_addr = vecs[i].addr; mem_req_data = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d ram_a", i), 32'(ram_a), 32'(vecs[i].addr[AW-1:0]));
            chk($sformatf("vec%0d ram_wr", i), 32'(ram_wr), 32'(vecs[i].r_w));
            chk($sformatf("vec%0d ram_dout", i), 32'(ram_dout), 32'(vecs[i].wdata));
            tick();
            if (vecs[i].r_w) shadow[vecs[i].addr[AW-1:0]] = vecs[i].wdata;
            else chk($sformatf("vec%0d rdata", i), 32'(mem_data_o), 32'(vecs[i].exp_rd));
        end
        mem_req = 1'b0; mem_r_w = 1'b0;
        tick();

        // Plain fetch and preempted fetch (MEM in the two cycles after byte1 issues).
        run_fetch(32'h0, 32'h0, 1'b0, "fetch0");
        run_fetch(32'h0, 32'b1100, 1'b0, "preempt");

        // if_clear with issue_cnt=2.
        if_req = 1'b1; if_addr = 32'h0;
        tick();
        if_req = 1'b0;
        tick();
        tick();
        if_clear = 1'b1;
        tick();
        if_clear = 1'b0;
        chk("clr busy", 32'(if_busy), 32'd0);
        chk("clr done", 32'(if_done), 32'd0);
        tick();
        chk("clr done2", 32'(if_done), 32'd0);
        run_fetch(32'h4, 32'h0, 1'b0, "after_clr");

        // Request together with clear is not accepted.
        if_req = 1'b1; if_clear = 1'b1;
        tick();
        if_req = 1'b0; if_clear = 1'b0;
        chk("clr_vs_req busy", 32'(if_busy), 32'd0);

        // Clear on the completing edge wins.
        if_req = 1'b1; if_addr = 32'h0;
        tick();
        if_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        if_clear = 1'b1;
        tick();
        if_clear = 1'b0;
        chk("clr_vs_done done", 32'(if_done), 32'd0);
        chk("clr_vs_done busy", 32'(if_busy), 32'd0);

        // Reset in the middle of a fetch.
        if_req = 1'b1; if_addr = 32'h4;
        tick();
        if_req = 1'b0;
        tick();
        tick();
        rst = 1'b1; mem_req = 1'b1; mem_r_w = 1'b1; mem_req_addr = 32'h200; mem_req_data = 8'hFF;
        #1;
        chk("rstmid ram_a", 32'(ram_a), 32'd0);
        chk("rstmid ram_wr", 32'(ram_wr), 32'd0);
        tick();
        chk("rstmid inst", if_inst_o, 32'd0);
        chk("rstmid busy", 32'(if_busy), 32'd0);
        chk("rstmid done", 32'(if_done), 32'd0);
        rst = 1'b0; mem_req = 1'b0; mem_r_w = 1'b0;
        begin
            bit any_done = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (if_done) any_done = 1;
            end
            chk("rstmid no_done", 32'(any_done), 32'd0);
        end

        // Address wrap across the top of the RAM.
        run_fetch(32'h0001FFFE, 32'h0, 1'b0, "wrap");

        // Randomized fetches with random MEM preemption.
        for (int i = 0; i < 64; i++) load(32'h400 + 32'(i), 8'($urandom));
        for (int i = 0; i < 16; i++) load(32'h800 + 32'(i), 8'($urandom));
        for (int i = 0; i < 25; i++) begin
            run_fetch(32'h400 + 32'($urandom_range(0, 60)), $urandom & $urandom, 1'b1,
                      $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
